control_unit: RTL and testbench
===============================

# control_unit

- Multi-cycle FSM controller for the K&S processor. Sits directly upstream of `data_path`.
- Drives every `data_path` control input and the RAM write strobe.
- Consumes the decoded instruction and the registered ALU flags that `data_path` returns.
- Sequences fetch, decode and execute for all instructions, including conditional branches and halt.

## Interface
Parameters: none. Word width (16 bits) and address width (5 bits) are fixed by `k_and_s_pkg`.

- `clk` in 1 — system clock; all state changes on the rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `decoded_instruction` in `decoded_instruction_type` — from `data_path`; valid from the DECODE state onward.
- `zero_op` in 1 — registered zero flag.
- `neg_op` in 1 — registered negative flag.
- `unsigned_overflow` in 1 — registered carry flag; unused by this block (kept for interface symmetry).
- `signed_overflow` in 1 — registered signed-overflow flag.
- `branch` out 1 — 1: PC loads the IR address field; 0: PC loads PC+1.
- `pc_enable` out 1 — PC register load.
- `ir_enable` out 1 — IR register load from `data_in`.
- `addr_sel` out 1 — 1: RAM address = IR address field; 0: RAM address = PC.
- `c_sel` out 1 — 1: register-write data = ALU result; 0: register-write data = `data_in`.
- `operation` out 2 — ALU op: 00 ADD, 01 SUB, 10 AND, 11 OR.
- `write_reg_enable` out 1 — register-file write.
- `flags_reg_enable` out 1 — flag register load.
- `ram_write_enable` out 1 — RAM write of `data_out` at `ram_addr`.
- `halted` out 1 — processor stopped.

## Operation
- Moore FSM. All outputs decode from the registered state only, except `branch` and `pc_enable` in BRANCH, which also depend on flags.
- Any output not listed for a state is 0.
- States and outputs:
  - FETCH: `addr_sel`=0, `ir_enable`=1. Next: DECODE.
  - DECODE: `pc_enable`=1, `branch`=0 (PC+1). Next state by `decoded_instruction`:
    - NOP → FETCH
    - LOAD → LOAD_1
    - STORE → STORE_1
    - MOVE → MOVE
    - ADD/SUB/AND/OR → ALU
    - any branch → BRANCH
    - HALT → HALT
  - LOAD_1: `addr_sel`=1 (RAM read-latency cycle). Next: LOAD_2.
  - LOAD_2: `addr_sel`=1, `c_sel`=0, `write_reg_enable`=1. Next: FETCH.
  - STORE_1: `addr_sel`=1, `ram_write_enable`=1. Next: FETCH.
  - MOVE: `c_sel`=1, `operation`=11, `write_reg_enable`=1, `flags_reg_enable`=0. Next: FETCH.
  - ALU: `c_sel`=1, `operation` = ADD 00 / SUB 01 / AND 10 / OR 11, `write_reg_enable`=1, `flags_reg_enable`=1. Next: FETCH.
  - BRANCH: `branch`=`taken`, `pc_enable`=`taken`. Next: FETCH.
  - HALT: `halted`=1, all enables 0. Stays in HALT until reset.
- Taken conditions:
  - BRANCH: always taken.
  - BZERO: `zero_op`=1. BNZERO: `zero_op`=0.
  - BNEG: `neg_op`=1. BNNEG: `neg_op`=0.
  - BOV: `signed_overflow`=1. BNOV: `signed_overflow`=0.
- Not taken: PC keeps the PC+1 value written in DECODE.
- Any unlisted or illegal `decoded_instruction` value is treated as NOP.

## Timing
- Reset: state = FETCH asynchronously. Outputs during reset are therefore the FETCH outputs:
  - `ir_enable`=1
  - `addr_sel`=0
  - all other outputs 0, including `halted`=0.
- First instruction fetch completes on the first rising edge after `rst_n` deasserts.
- Cycles per instruction, FETCH included:
  - NOP 2
  - STORE 3
  - MOVE 3
  - ALU 3
  - any branch 3
  - LOAD 4
  - HALT terminal
- Flag evaluation in BRANCH uses flags registered by the most recent ALU state. An ALU instruction followed immediately by a branch sees the updated flags, because the flags were written at the ALU→FETCH edge.
- `rst_n` asserted in any state, including HALT or mid-LOAD: immediate return to FETCH. No partial register write or RAM write may be issued after the assert.
- `ram_write_enable` and `write_reg_enable` are never 1 in the same cycle.
- `ir_enable` is 1 only in FETCH.

## Structure
- `k_and_s_pkg` additions:
  - `ctrl_state_type` enum: FETCH, DECODE, LOAD_1, LOAD_2, STORE_1, MOVE, ALU, BRANCH, HALT.
  - ALU op constants `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`.
  - `decoded_instruction_type` is shared with `data_path` and lives in the package unchanged.
- One sub-module: `branch_condition`. Purely combinational; maps (`decoded_instruction`, flags) to `taken`.

## Test plan
- Reset release, IR=NOP: `ir_enable`=1, then DECODE with `pc_enable`=1, then FETCH. Period 2 cycles.
- ADD: ALU state shows `operation`=00, `c_sel`=1, `write_reg_enable`=1, `flags_reg_enable`=1 for exactly one cycle.
- LOAD: two cycles of `addr_sel`=1; `write_reg_enable`=1 with `c_sel`=0 only in the second. STORE: one cycle of `ram_write_enable`=1 with `addr_sel`=1.
- BZERO: with `zero_op`=1, `branch`=1 and `pc_enable`=1 in BRANCH. With `zero_op`=0, both are 0. Repeat for BNZERO, BNEG, BNNEG, BOV, BNOV.
- HALT: `halted`=1 and all enables 0 held for 20 cycles. Then `rst_n`=0 asynchronously mid-cycle: `halted`=0 and `ir_enable`=1 before the next clock edge.
- Reset in LOAD_1: state returns to FETCH; no `write_reg_enable` pulse appears.

Source files
------------

// File: rtl/k_and_s_pkg.sv
// Shared types and constants for the K&S processor: instruction decode
// values exchanged with data_path, controller states and ALU op codes.
package k_and_s_pkg;

   // Decoded instruction as produced by data_path. Five bits leave room
   // for values that no instruction uses; the controller treats those as NOP.
   typedef enum logic [4:0] {
      I_NOP    = 5'd0,
      I_LOAD   = 5'd1,
      I_STORE  = 5'd2,
      I_MOVE   = 5'd3,
      I_ADD    = 5'd4,
      I_SUB    = 5'd5,
      I_AND    = 5'd6,
      I_OR     = 5'd7,
      I_BRANCH = 5'd8,
      I_BZERO  = 5'd9,
      I_BNZERO = 5'd10,
      I_BNEG   = 5'd11,
      I_BNNEG  = 5'd12,
      I_BOV    = 5'd13,
      I_BNOV   = 5'd14,
      I_HALT   = 5'd15
   } decoded_instruction_type;

   // Controller states
   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      LOAD_1  = 4'd2,
      LOAD_2  = 4'd3,
      STORE_1 = 4'd4,
      MOVE    = 4'd5,
      ALU     = 4'd6,
      BRANCH  = 4'd7,
      HALT    = 4'd8
   } ctrl_state_type;

   // ALU operation select codes
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   // True for every conditional or unconditional branch instruction
   function automatic logic is_branch(input decoded_instruction_type instr);
      is_branch = (instr == I_BRANCH) || (instr == I_BZERO)  ||
                  (instr == I_BNZERO) || (instr == I_BNEG)   ||
                  (instr == I_BNNEG)  || (instr == I_BOV)    ||
                  (instr == I_BNOV);
   endfunction

endpackage

// File: rtl/control_unit_branch_condition.sv
// Combinational branch resolver: decides whether the branch held in the
// IR is taken, given the flags registered by the most recent ALU operation.
module branch_condition
   import k_and_s_pkg::*;
(
   input  decoded_instruction_type decoded_instruction,
   input  logic                    zero_op,
   input  logic                    neg_op,
   input  logic                    signed_overflow,
   output logic                    taken
);

   // Map the branch kind onto the flag it tests; non-branches never take
   always_comb begin
      taken = 1'b0;
      case (decoded_instruction)
         I_BRANCH: taken = 1'b1;
         I_BZERO:  taken = zero_op;
         I_BNZERO: taken = ~zero_op;
         I_BNEG:   taken = neg_op;
         I_BNNEG:  taken = ~neg_op;
         I_BOV:    taken = signed_overflow;
         I_BNOV:   taken = ~signed_overflow;
         default:  taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle Moore controller for the K&S processor. Sequences fetch,
// decode and execute and drives every data_path control plus the RAM
// write strobe. Only BRANCH lets the flags reach the outputs.
module control_unit
   import k_and_s_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  decoded_instruction_type decoded_instruction,
   input  logic                    zero_op,
   input  logic                    neg_op,
   input  logic                    unsigned_overflow,
   input  logic                    signed_overflow,
   output logic                    branch,
   output logic                    pc_enable,
   output logic                    ir_enable,
   output logic                    addr_sel,
   output logic                    c_sel,
   output logic [1:0]              operation,
   output logic                    write_reg_enable,
   output logic                    flags_reg_enable,
   output logic                    ram_write_enable,
   output logic                    halted
);

   ctrl_state_type r_state;
   ctrl_state_type w_next_state;
   logic           w_taken;
   logic           w_unused_carry;

   // The carry flag is part of the data_path flag bundle but no branch tests it
   assign w_unused_carry = unsigned_overflow;

   branch_condition u_branch_condition (
      .decoded_instruction (decoded_instruction),
      .zero_op             (zero_op),
      .neg_op              (neg_op),
      .signed_overflow     (signed_overflow),
      .taken               (w_taken)
   );

   // State register; reset forces FETCH at once, even in HALT or mid-LOAD
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= FETCH;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state selection; unknown instructions fall back to NOP behaviour
   always_comb begin
      w_next_state = FETCH;
      case (r_state)
         FETCH:   w_next_state = DECODE;
         DECODE: begin
            case (decoded_instruction)
               I_LOAD:  w_next_state = LOAD_1;
               I_STORE: w_next_state = STORE_1;
               I_MOVE:  w_next_state = MOVE;
               I_ADD,
               I_SUB,
               I_AND,
               I_OR:    w_next_state = ALU;
               I_HALT:  w_next_state = HALT;
               default: w_next_state = is_branch(decoded_instruction) ? BRANCH : FETCH;
            endcase
         end
         LOAD_1:  w_next_state = LOAD_2;
         LOAD_2:  w_next_state = FETCH;
         STORE_1: w_next_state = FETCH;
         MOVE:    w_next_state = FETCH;
         ALU:     w_next_state = FETCH;
         BRANCH:  w_next_state = FETCH;
         HALT:    w_next_state = HALT;
         default: w_next_state = FETCH;
      endcase
   end

   // Output decode from the registered state; everything idles at 0 unless named
   always_comb begin
      branch           = 1'b0;
      pc_enable        = 1'b0;
      ir_enable        = 1'b0;
      addr_sel         = 1'b0;
      c_sel            = 1'b0;
      operation        = ALU_ADD;
      write_reg_enable = 1'b0;
      flags_reg_enable = 1'b0;
      ram_write_enable = 1'b0;
      halted           = 1'b0;
      case (r_state)
         FETCH: begin
            ir_enable = 1'b1;
         end
         DECODE: begin
            pc_enable = 1'b1;
         end
         LOAD_1: begin
            addr_sel = 1'b1;
         end
         LOAD_2: begin
            addr_sel         = 1'b1;
            write_reg_enable = 1'b1;
         end
         STORE_1: begin
            addr_sel         = 1'b1;
            ram_write_enable = 1'b1;
         end
         MOVE: begin
            c_sel            = 1'b1;
            operation        = ALU_OR;
            write_reg_enable = 1'b1;
         end
         ALU: begin
            c_sel            = 1'b1;
            write_reg_enable = 1'b1;
            flags_reg_enable = 1'b1;
            case (decoded_instruction)
               I_SUB:   operation = ALU_SUB;
               I_AND:   operation = ALU_AND;
               I_OR:    operation = ALU_OR;
               default: operation = ALU_ADD;
            endcase
         end
         BRANCH: begin
            branch    = w_taken;
            pc_enable = w_taken;
         end
         HALT: begin
            halted = 1'b1;
         end
         default: begin
            ir_enable = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks every instruction class, each
// branch with its flag both set and clear, HALT and asynchronous reset.
module tb_control_unit;
   import k_and_s_pkg::*;

   logic                    clk;
   logic                    rst_n;
   decoded_instruction_type r_instr;
   logic                    r_zero;
   logic                    r_neg;
   logic                    r_carry;
   logic                    r_ovf;
   logic                    w_branch;
   logic                    w_pc_enable;
   logic                    w_ir_enable;
   logic                    w_addr_sel;
   logic                    w_c_sel;
   logic [1:0]              w_operation;
   logic                    w_write_reg_enable;
   logic                    w_flags_reg_enable;
   logic                    w_ram_write_enable;
   logic                    w_halted;
   logic [10:0]             w_obs;

   int assertCount;
   int failCount;

   // Expected output vectors, bit order:
   // {branch, pc_en, ir_en, addr_sel, c_sel, op[1:0], wr_reg, flags, ram_we, halted}
   localparam logic [10:0] EXP_FETCH   = 11'b00100_00_0000;
   localparam logic [10:0] EXP_DECODE  = 11'b01000_00_0000;
   localparam logic [10:0] EXP_ADD     = 11'b00001_00_1100;
   localparam logic [10:0] EXP_SUB     = 11'b00001_01_1100;
   localparam logic [10:0] EXP_AND     = 11'b00001_10_1100;
   localparam logic [10:0] EXP_OR      = 11'b00001_11_1100;
   localparam logic [10:0] EXP_MOVE    = 11'b00001_11_1000;
   localparam logic [10:0] EXP_LOAD1   = 11'b00010_00_0000;
   localparam logic [10:0] EXP_LOAD2   = 11'b00010_00_1000;
   localparam logic [10:0] EXP_STORE1  = 11'b00010_00_0010;
   localparam logic [10:0] EXP_BR_TAKE = 11'b11000_00_0000;
   localparam logic [10:0] EXP_BR_SKIP = 11'b00000_00_0000;
   localparam logic [10:0] EXP_HALT    = 11'b00000_00_0001;

   control_unit dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .decoded_instruction (r_instr),
      .zero_op             (r_zero),
      .neg_op              (r_neg),
      .unsigned_overflow   (r_carry),
      .signed_overflow     (r_ovf),
      .branch              (w_branch),
      .pc_enable           (w_pc_enable),
      .ir_enable           (w_ir_enable),
      .addr_sel            (w_addr_sel),
      .c_sel               (w_c_sel),
      .operation           (w_operation),
      .write_reg_enable    (w_write_reg_enable),
      .flags_reg_enable    (w_flags_reg_enable),
      .ram_write_enable    (w_ram_write_enable),
      .halted              (w_halted)
   );

   assign w_obs = {w_branch, w_pc_enable, w_ir_enable, w_addr_sel, w_c_sel,
                   w_operation, w_write_reg_enable, w_flags_reg_enable,
                   w_ram_write_enable, w_halted};

   // Free-running 10-unit clock; outputs are sampled on the falling edge
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare the whole output vector against a hand-derived value
   task automatic checkOutput(input string tag, input logic [10:0] expected);
      assertCount++;
      assert (w_obs === expected)
         else begin
            failCount++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, w_obs, expected);
         end
   endtask

   // Advance one cycle to the next falling edge, then compare
   task automatic applyStimulus(input string tag, input logic [10:0] expected);
      @(negedge clk);
      checkOutput(tag, expected);
   endtask

   // One branch instruction from FETCH back to FETCH with the given flags
   task automatic runBranch(input string tag, input decoded_instruction_type instr,
                            input logic z, input logic n, input logic v,
                            input logic taken);
      r_instr = instr;
      r_zero  = z;
      r_neg   = n;
      r_ovf   = v;
      r_carry = ~v;
      checkOutput({tag, "_fetch"}, EXP_FETCH);
      applyStimulus({tag, "_decode"}, EXP_DECODE);
      applyStimulus({tag, "_branch"}, taken ? EXP_BR_TAKE : EXP_BR_SKIP);
      @(negedge clk);
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      r_instr     = I_NOP;
      r_zero      = 1'b0;
      r_neg       = 1'b0;
      r_carry     = 1'b0;
      r_ovf       = 1'b0;
      rst_n       = 1'b1;

      // Asynchronous reset with no clock edge yet
      #1 rst_n = 1'b0;
      #1 checkOutput("reset_async", EXP_FETCH);
      @(negedge clk);
      checkOutput("reset_held", EXP_FETCH);
      rst_n = 1'b1;

      // NOP period of two cycles
      checkOutput("nop_fetch", EXP_FETCH);
      applyStimulus("nop_decode", EXP_DECODE);
      applyStimulus("nop_fetch2", EXP_FETCH);
      applyStimulus("nop_decode2", EXP_DECODE);
      @(negedge clk);

      // ADD, exactly one ALU cycle
      r_instr = I_ADD;
      checkOutput("add_fetch", EXP_FETCH);
      applyStimulus("add_decode", EXP_DECODE);
      applyStimulus("add_alu", EXP_ADD);
      applyStimulus("add_back_fetch", EXP_FETCH);

      // SUB, AND, OR operation codes
      r_instr = I_SUB;
      applyStimulus("sub_decode", EXP_DECODE);
      applyStimulus("sub_alu", EXP_SUB);
      @(negedge clk);
      r_instr = I_AND;
      applyStimulus("and_decode", EXP_DECODE);
      applyStimulus("and_alu", EXP_AND);
      @(negedge clk);
      r_instr = I_OR;
      applyStimulus("or_decode", EXP_DECODE);
      applyStimulus("or_alu", EXP_OR);
      applyStimulus("or_back_fetch", EXP_FETCH);

      // MOVE writes the register but leaves flags alone
      r_instr = I_MOVE;
      applyStimulus("move_decode", EXP_DECODE);
      applyStimulus("move_exec", EXP_MOVE);
      applyStimulus("move_back_fetch", EXP_FETCH);

      // LOAD: two address cycles, write only in the second
      r_instr = I_LOAD;
      applyStimulus("load_decode", EXP_DECODE);
      applyStimulus("load_1", EXP_LOAD1);
      applyStimulus("load_2", EXP_LOAD2);
      applyStimulus("load_back_fetch", EXP_FETCH);

      // STORE: one RAM write cycle
      r_instr = I_STORE;
      applyStimulus("store_decode", EXP_DECODE);
      applyStimulus("store_1", EXP_STORE1);
      applyStimulus("store_back_fetch", EXP_FETCH);

      // Illegal instruction code behaves as NOP
      r_instr = decoded_instruction_type'(5'd20);
      applyStimulus("illegal_decode", EXP_DECODE);
      applyStimulus("illegal_fetch", EXP_FETCH);

      // Every branch with its tested flag set and clear, other flags opposed
      runBranch("br_always", I_BRANCH, 1'b0, 1'b0, 1'b0, 1'b1);
      runBranch("bz_set",    I_BZERO,  1'b1, 1'b0, 1'b0, 1'b1);
      runBranch("bz_clr",    I_BZERO,  1'b0, 1'b1, 1'b1, 1'b0);
      runBranch("bnz_clr",   I_BNZERO, 1'b0, 1'b1, 1'b1, 1'b1);
      runBranch("bnz_set",   I_BNZERO, 1'b1, 1'b0, 1'b0, 1'b0);
      runBranch("bneg_set",  I_BNEG,   1'b0, 1'b1, 1'b0, 1'b1);
      runBranch("bneg_clr",  I_BNEG,   1'b1, 1'b0, 1'b1, 1'b0);
      runBranch("bnneg_clr", I_BNNEG,  1'b1, 1'b0, 1'b1, 1'b1);
      runBranch("bnneg_set", I_BNNEG,  1'b0, 1'b1, 1'b0, 1'b0);
      runBranch("bov_set",   I_BOV,    1'b0, 1'b0, 1'b1, 1'b1);
      runBranch("bov_clr",   I_BOV,    1'b1, 1'b1, 1'b0, 1'b0);
      runBranch("bnov_clr",  I_BNOV,   1'b1, 1'b1, 1'b0, 1'b1);
      runBranch("bnov_set",  I_BNOV,   1'b0, 1'b0, 1'b1, 1'b0);

      // Reset asserted mid-cycle in LOAD_1 cancels the pending register write
      r_instr = I_LOAD;
      checkOutput("ldrst_fetch", EXP_FETCH);
      applyStimulus("ldrst_decode", EXP_DECODE);
      applyStimulus("ldrst_load1", EXP_LOAD1);
      #2 rst_n = 1'b0;
      #1 checkOutput("ldrst_async", EXP_FETCH);
      applyStimulus("ldrst_held", EXP_FETCH);
      rst_n = 1'b1;
      applyStimulus("ldrst_decode2", EXP_DECODE);
      applyStimulus("ldrst_load1b", EXP_LOAD1);
      applyStimulus("ldrst_load2b", EXP_LOAD2);
      applyStimulus("ldrst_fetch2", EXP_FETCH);

      // HALT holds for 20 cycles until an asynchronous reset
      r_instr = I_HALT;
      applyStimulus("halt_decode", EXP_DECODE);
      for (int i = 0; i < 20; i++) begin
         applyStimulus($sformatf("halt_hold_%0d", i), EXP_HALT);
      end
      #2 rst_n = 1'b0;
      #1 checkOutput("halt_reset_async", EXP_FETCH);
      @(negedge clk);
      r_instr = I_NOP;
      rst_n   = 1'b1;
      checkOutput("halt_reset_fetch", EXP_FETCH);
      applyStimulus("halt_reset_decode", EXP_DECODE);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
